// File: rtl/vip_bit_target_locator_if.sv
// -----------------------------------------------------------------------------
// vip_bit_target_locator_if
// Bundles the video stream and result signals of vip_bit_target_locator.
//   per_frame_vsync/href/clken, per_img_Bit : incoming binary video stream
//   post_frame_vsync/href/clken, post_img_Bit : 1-clk delayed video stream
//   target_xmin/xmax/ymin/ymax (11)           : bounding box of last frame
//   target_cnt (20), target_valid, frame_done : count, validity, update pulse
// Modports: master = video source / result consumer, slave = the locator.
// -----------------------------------------------------------------------------
interface vip_bit_target_locator_if;
   logic        per_frame_vsync;
   logic        per_frame_href;
   logic        per_frame_clken;
   logic        per_img_Bit;
   logic        post_frame_vsync;
   logic        post_frame_href;
   logic        post_frame_clken;
   logic        post_img_Bit;
   logic [10:0] target_xmin;
   logic [10:0] target_xmax;
   logic [10:0] target_ymin;
   logic [10:0] target_ymax;
   logic [19:0] target_cnt;
   logic        target_valid;
   logic        frame_done;

   modport master (
      output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
      input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
      input  target_xmin, target_xmax, target_ymin, target_ymax,
      input  target_cnt, target_valid, frame_done
   );

   modport slave (
      input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
      output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
      output target_xmin, target_xmax, target_ymin, target_ymax,
      output target_cnt, target_valid, frame_done
   );
endinterface

// File: rtl/vip_bit_target_locator.sv
// -----------------------------------------------------------------------------
// vip_bit_target_locator
// Finds the bounding box and set-pixel count of a binary (eroded) image frame
// and passes the video stream through with one clock of latency.
// Ports:
//   clk : pixel clock
//   rst : synchronous active-high reset
//   vif : vip_bit_target_locator_if.slave (video in/out, frame results)
// Parameters: IMG_HDISP, IMG_VDISP (active size), MIN_PIXELS (valid threshold)
// Optional feature: define BOX_OVERLAY_EN to draw the previous frame's box
// perimeter onto post_img_Bit while that result is valid.
// -----------------------------------------------------------------------------
module vip_bit_target_locator #(
   parameter int IMG_HDISP  = 640,
   parameter int IMG_VDISP  = 480,
   parameter int MIN_PIXELS = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   vip_bit_target_locator_if.slave    vif
);
   localparam logic [10:0] X_MAX   = 11'(IMG_HDISP - 1);
   localparam logic [10:0] Y_MAX   = 11'(IMG_VDISP - 1);
   localparam logic [19:0] CNT_MAX = 20'hFFFFF;
   localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_LATCH = 2'd2} state_t;

   state_t      state_r, state_nxt_s;
   logic        post_vsync_r, post_href_r, post_clken_r, post_bit_r;
   logic        arm_r;
   logic [10:0] x_r, y_r;
   logic [10:0] xmin_r, xmax_r, ymin_r, ymax_r;
   logic [19:0] cnt_r;
   logic [10:0] txmin_r, txmax_r, tymin_r, tymax_r;
   logic [19:0] tcnt_r;
   logic        tvalid_r, frame_done_r;
   logic        vsync_rise_s, vsync_fall_s, href_fall_s, pix_s, pix_set_s;
   logic        acc_init_s, acc_en_s, latch_s, overlay_s;

   // Edge detection; the delayed post_* registers double as the edge copies.
   // arm_r blocks a false rise when vsync is already high as reset releases.
   always_comb begin
      vsync_rise_s = vif.per_frame_vsync & ~post_vsync_r & arm_r;
      vsync_fall_s = ~vif.per_frame_vsync & post_vsync_r;
      href_fall_s  = ~vif.per_frame_href & post_href_r;
      pix_s        = vif.per_frame_clken & vif.per_frame_href;
      pix_set_s    = pix_s & vif.per_img_Bit;
   end

   // Box overlay: current pixel lies on the perimeter of the latched box.
`ifdef BOX_OVERLAY_EN
   always_comb begin
      overlay_s = pix_s & tvalid_r &
                  ((((x_r == txmin_r) || (x_r == txmax_r)) && (y_r >= tymin_r) && (y_r <= tymax_r)) ||
                   (((y_r == tymin_r) || (y_r == tymax_r)) && (x_r >= txmin_r) && (x_r <= txmax_r)));
   end
`else
   always_comb begin
      overlay_s = 1'b0;
   end
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE:   if (vsync_rise_s) state_nxt_s = S_ACTIVE; else state_nxt_s = S_IDLE;
         S_ACTIVE: if (vsync_fall_s) state_nxt_s = S_LATCH;  else state_nxt_s = S_ACTIVE;
         S_LATCH:  if (vsync_rise_s) state_nxt_s = S_ACTIVE; else state_nxt_s = S_IDLE;
         default:  state_nxt_s = S_IDLE;
      endcase
   end

   // FSM outputs: accumulator init on ACTIVE entry, accumulate, latch results.
   always_comb begin
      acc_init_s = 1'b0;
      acc_en_s   = 1'b0;
      latch_s    = 1'b0;
      case (state_r)
         S_IDLE:   acc_init_s = (state_nxt_s == S_ACTIVE);
         S_ACTIVE: begin
            acc_en_s = 1'b1;
            latch_s  = (state_nxt_s == S_LATCH);
         end
         S_LATCH:  acc_init_s = (state_nxt_s == S_ACTIVE);
         default:  acc_init_s = 1'b0;
      endcase
   end

   // Delayed video stream and vsync arming flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         post_vsync_r <= 1'b0;
         post_href_r  <= 1'b0;
         post_clken_r <= 1'b0;
         post_bit_r   <= 1'b0;
         arm_r        <= 1'b0;
      end else begin
         post_vsync_r <= vif.per_frame_vsync;
         post_href_r  <= vif.per_frame_href;
         post_clken_r <= vif.per_frame_clken;
         post_bit_r   <= (vif.per_img_Bit & vif.per_frame_href) | overlay_s;
         arm_r        <= arm_r | ~vif.per_frame_vsync;
      end
   end

   // Pixel x/y position counters, both saturating.
   always_ff @(posedge clk) begin
      if (rst || acc_init_s) begin
         x_r <= 11'd0;
         y_r <= 11'd0;
      end else if (href_fall_s) begin
         x_r <= 11'd0;
         y_r <= (y_r == Y_MAX) ? y_r : y_r + 11'd1;
      end else if (pix_s && (x_r != X_MAX)) begin
         x_r <= x_r + 11'd1;
      end else begin
         x_r <= x_r;
      end
   end

   // Working min/max/count accumulators for the frame in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         xmin_r <= 11'd0;
         xmax_r <= 11'd0;
         ymin_r <= 11'd0;
         ymax_r <= 11'd0;
         cnt_r  <= 20'd0;
      end else if (acc_init_s) begin
         xmin_r <= 11'd2047;
         xmax_r <= 11'd0;
         ymin_r <= 11'd2047;
         ymax_r <= 11'd0;
         cnt_r  <= 20'd0;
      end else if (acc_en_s && pix_set_s) begin
         xmin_r <= (x_r < xmin_r) ? x_r : xmin_r;
         xmax_r <= (x_r > xmax_r) ? x_r : xmax_r;
         ymin_r <= (y_r < ymin_r) ? y_r : ymin_r;
         ymax_r <= (y_r > ymax_r) ? y_r : ymax_r;
         cnt_r  <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 20'd1;
      end else begin
         cnt_r  <= cnt_r;
      end
   end

   // Result registers; loaded so they are visible during the LATCH cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         txmin_r      <= 11'd0;
         txmax_r      <= 11'd0;
         tymin_r      <= 11'd0;
         tymax_r      <= 11'd0;
         tcnt_r       <= 20'd0;
         tvalid_r     <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= latch_s;
         if (latch_s) begin
            // An empty frame reports an all-zero box instead of the init values.
            txmin_r  <= (cnt_r == 20'd0) ? 11'd0 : xmin_r;
            txmax_r  <= (cnt_r == 20'd0) ? 11'd0 : xmax_r;
            tymin_r  <= (cnt_r == 20'd0) ? 11'd0 : ymin_r;
            tymax_r  <= (cnt_r == 20'd0) ? 11'd0 : ymax_r;
            tcnt_r   <= cnt_r;
            tvalid_r <= (cnt_r != 20'd0) && (cnt_r >= MIN_CNT);
         end else begin
            tvalid_r <= tvalid_r;
         end
      end
   end

   assign vif.post_frame_vsync = post_vsync_r;
   assign vif.post_frame_href  = post_href_r;
   assign vif.post_frame_clken = post_clken_r;
   assign vif.post_img_Bit     = post_bit_r;
   assign vif.target_xmin      = txmin_r;
   assign vif.target_xmax      = txmax_r;
   assign vif.target_ymin      = tymin_r;
   assign vif.target_ymax      = tymax_r;
   assign vif.target_cnt       = tcnt_r;
   assign vif.target_valid     = tvalid_r;
   assign vif.frame_done       = frame_done_r;
endmodule

// File: tb/tb_vip_bit_target_locator.sv
// -----------------------------------------------------------------------------
// tb_vip_bit_target_locator
// Directed frames on an 8x6 image; expected results are queued when a frame
// is issued and compared by a monitor whenever frame_done pulses. The monitor
// also checks the 1-clk delayed stream every cycle (including the box overlay
// when BOX_OVERLAY_EN is defined).
// -----------------------------------------------------------------------------
module tb_vip_bit_target_locator;
   localparam int H    = 8;
   localparam int V    = 6;
   localparam int MINP = 4;
`ifdef BOX_OVERLAY_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   typedef struct packed {
      logic [10:0] xmin;
      logic [10:0] xmax;
      logic [10:0] ymin;
      logic [10:0] ymax;
      logic [19:0] cnt;
      logic        valid;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   res_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   px = 0;
   int   py = 0;

   vip_bit_target_locator_if vif();

   vip_bit_target_locator #(.IMG_HDISP(H), .IMG_VDISP(V), .MIN_PIXELS(MINP)) dut (
      .clk (clk),
      .rst (rst),
      .vif (vif.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic bit on_box(input int x, input int y, input res_t b);
      return (((x == int'(b.xmin)) || (x == int'(b.xmax))) && (y >= int'(b.ymin)) && (y <= int'(b.ymax))) ||
             (((y == int'(b.ymin)) || (y == int'(b.ymax))) && (x >= int'(b.xmin)) && (x <= int'(b.xmax)));
   endfunction

   function automatic logic [47:0] set_px(input logic [47:0] m, input int x, input int y);
      return m | (48'd1 << (y * H + x));
   endfunction

   function automatic res_t mk(input int x0, input int x1, input int y0, input int y1,
                               input int c, input bit v);
      res_t r;
      r.xmin = 11'(x0); r.xmax = 11'(x1); r.ymin = 11'(y0); r.ymax = 11'(y1);
      r.cnt = 20'(c); r.valid = v;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one frame; rst_line >= 0 pulses reset for one cycle before that line.
   task automatic drive_frame(input logic [47:0] pix, input int gap, input int rst_line);
      vif.per_frame_vsync = 1'b1;
      tick();
      tick();
      for (int y = 0; y < V; y++) begin
         if (y == rst_line) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         for (int x = 0; x < H; x++) begin
            px = x;
            py = y;
            vif.per_frame_href  = 1'b1;
            vif.per_frame_clken = 1'b1;
            vif.per_img_Bit     = pix[y * H + x];
            tick();
         end
         vif.per_frame_href  = 1'b0;
         vif.per_frame_clken = 1'b0;
         vif.per_img_Bit     = 1'b0;
         tick();
         tick();
      end
      vif.per_frame_vsync = 1'b0;
      repeat (gap) tick();
   endtask

   // Monitor: previous-cycle inputs predict this cycle's delayed stream.
   logic p_vs = 1'b0, p_hr = 1'b0, p_ck = 1'b0, p_bit = 1'b0, p_rst = 1'b1;
   logic p_fd = 1'b0, p_postvs = 1'b0;
   int   p_x = 0, p_y = 0;
   res_t mb = '0;

   always @(negedge clk) begin
      logic [3:0] exp_s;
      res_t e;
      if (p_rst) begin
         exp_s = 4'b0000;
      end else begin
         exp_s = {p_vs, p_hr, p_ck,
                  (p_bit & p_hr) | (OVL & p_ck & p_hr & mb.valid & on_box(p_x, p_y, mb))};
      end
      check("stream", {28'd0, vif.post_frame_vsync, vif.post_frame_href,
                       vif.post_frame_clken, vif.post_img_Bit}, {28'd0, exp_s});
      if (p_rst) mb.valid = 1'b0;
      if (vif.frame_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame_done: got 1, expected 0");
         end else begin
            e = exp_q.pop_front();
            check("xmin",  32'(vif.target_xmin),  32'(e.xmin));
            check("xmax",  32'(vif.target_xmax),  32'(e.xmax));
            check("ymin",  32'(vif.target_ymin),  32'(e.ymin));
            check("ymax",  32'(vif.target_ymax),  32'(e.ymax));
            check("cnt",   32'(vif.target_cnt),   32'(e.cnt));
            check("valid", 32'(vif.target_valid), 32'(e.valid));
            // pulse lands one clk after the vsync fall and is a fresh pulse
            check("done_timing", {29'd0, p_postvs, vif.post_frame_vsync, p_fd}, 32'd4);
            mb = e;
         end
      end
      p_vs     = vif.per_frame_vsync;
      p_hr     = vif.per_frame_href;
      p_ck     = vif.per_frame_clken;
      p_bit    = vif.per_img_Bit;
      p_x      = px;
      p_y      = py;
      p_rst    = rst;
      p_fd     = vif.frame_done;
      p_postvs = vif.post_frame_vsync;
   end

   initial begin
      logic [47:0] m1, m3, ma, mb_px;
      int          waited;
      vif.per_frame_vsync = 1'b0;
      vif.per_frame_href  = 1'b0;
      vif.per_frame_clken = 1'b0;
      vif.per_img_Bit     = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_xmin",  32'(vif.target_xmin), 32'd0);
      check("rst_ymax",  32'(vif.target_ymax), 32'd0);
      check("rst_cnt",   32'(vif.target_cnt), 32'd0);
      check("rst_flags", {30'd0, vif.target_valid, vif.frame_done}, 32'd0);

      // four-corner target
      m1 = '0;
      m1 = set_px(m1, 2, 1); m1 = set_px(m1, 5, 1);
      m1 = set_px(m1, 2, 4); m1 = set_px(m1, 5, 4);
      exp_q.push_back(mk(2, 5, 1, 4, 4, 1'b1));
      drive_frame(m1, 4, -1);

      // empty frame (overlay of the previous box when enabled)
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1'b0));
      drive_frame(48'd0, 4, -1);

      // single pixel at the far corner, below threshold
      m3 = set_px(48'd0, 7, 5);
      exp_q.push_back(mk(7, 7, 5, 5, 1, 1'b0));
      drive_frame(m3, 4, -1);

      // reset during line 3: frame is dropped and results cleared
      drive_frame(m1, 4, 3);
      check("post_rst_xmax",  32'(vif.target_xmax), 32'd0);
      check("post_rst_cnt",   32'(vif.target_cnt), 32'd0);
      check("post_rst_valid", 32'(vif.target_valid), 32'd0);

      // next full frame reports normally
      exp_q.push_back(mk(2, 5, 1, 4, 4, 1'b1));
      drive_frame(m1, 4, -1);

      // back-to-back frames with a single-cycle vsync gap
      ma = '0;
      ma = set_px(ma, 0, 0); ma = set_px(ma, 7, 5); ma = set_px(ma, 3, 2);
      ma = set_px(ma, 4, 3); ma = set_px(ma, 1, 1);
      mb_px = '0;
      mb_px = set_px(mb_px, 6, 2); mb_px = set_px(mb_px, 6, 3);
      mb_px = set_px(mb_px, 5, 2); mb_px = set_px(mb_px, 4, 2);
      exp_q.push_back(mk(0, 7, 0, 5, 5, 1'b1));
      drive_frame(ma, 1, -1);
      exp_q.push_back(mk(4, 6, 2, 3, 4, 1'b1));
      drive_frame(mb_px, 4, -1);

      waited = 0;
      while ((exp_q.size() != 0) && (waited < 20)) begin
         tick();
         waited++;
      end
      check("frames_reported", 32'(exp_q.size()), 32'd0);
      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
